// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream bootloader and the RAM decode.
package mem_loader_pkg;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] INSTR_BASE     = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        BYTES,
        WRITE,
        FIN
    } loader_state_t;

    // Byte address of word 'index' in a segment starting at 'base'.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Stream-in, RAM write-out and status signals of the loader, bundled as one port.
interface mem_loader_if;

    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        busy;
    logic        done;
    logic        err;

    // master: the loader itself (initiator of RAM writes, consumer of the byte stream)
    modport master (
        input  start, in_valid, in_data,
        output in_ready, wr_en, addr, w_data, busy, done, err
    );

    // slave: the byte source / RAM / top-level glue facing the loader
    modport slave (
        output start, in_valid, in_data,
        input  in_ready, wr_en, addr, w_data, busy, done, err
    );

endinterface

// File: rtl/mem_loader_word_assembler.sv
// Packs little-endian bytes into a 32-bit word; word_full flags the 4th byte of a word.
module word_assembler
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (load) begin
            word[8*cnt +: 8] <= data;
            cnt              <= cnt + 1'b1;
        end
    end

    assign word_full = load && (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// Length-prefixed byte-stream bootloader: packs bytes into words and writes them to RAM,
// holding each write long enough to span a full period of the divided core clock.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = INSTR_BASE,
    parameter int          MAX_WORDS   = 512,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic         clk_100M,
    input  logic         reset,
    mem_loader_if.master bus
);

    localparam int IDX_W  = $clog2(MAX_WORDS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    loader_state_t     state, next_state;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [IDX_W-1:0]  index;
    logic [HOLD_W-1:0] hold_cnt;
    logic              err_q;
    logic [31:0]       word;
    logic              word_full;

    logic        accept, start_go, hold_last, last_word, len_bad;
    logic [15:0] len_full;

    assign accept    = bus.in_valid && bus.in_ready;
    assign start_go  = (state == IDLE) && bus.start;
    assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign last_word = ((32'(index) + 32'd1) == 32'(len));
    assign len_full  = {bus.in_data, len_lo};
    assign len_bad   = (32'(len_full) > 32'(MAX_WORDS));

    word_assembler u_word_assembler (
        .clk       (clk_100M),
        .rst       (reset),
        .clear     (start_go),
        .load      (accept && (state == BYTES)),
        .data      (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        next_state   = state;
        bus.in_ready = 1'b0;
        bus.wr_en    = 1'b0;
        bus.busy     = (state != IDLE);
        bus.done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = LEN_LO;
            end
            LEN_LO: begin
                bus.in_ready = 1'b1;
                if (accept) next_state = LEN_HI;
            end
            LEN_HI: begin
                bus.in_ready = 1'b1;
                if (accept) next_state = ((len_full == 16'd0) || len_bad) ? FIN : BYTES;
            end
            BYTES: begin
                bus.in_ready = 1'b1;
                if (word_full) next_state = WRITE;
            end
            WRITE: begin
                bus.wr_en = 1'b1;
                if (hold_last) next_state = last_word ? FIN : BYTES;
            end
            FIN: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Index returns to zero after the last word so addr never points past the loaded image.
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            len_lo   <= '0;
            len      <= '0;
            index    <= '0;
            hold_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start_go) begin
                err_q <= 1'b0;
                index <= '0;
            end
            if ((state == LEN_LO) && accept) len_lo <= bus.in_data;
            if ((state == LEN_HI) && accept) begin
                len <= len_full;
                if (len_bad) err_q <= 1'b1;
            end
            if (state == WRITE) begin
                if (hold_last) begin
                    hold_cnt <= '0;
                    index    <= last_word ? '0 : index + 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.addr   = word_addr(BASE_ADDR, 32'(index));
    assign bus.w_data = word;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: normal, zero-length, over-length, gaps, reset mid-load, stray start.
module tb_mem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam int          HOLD = 4;

    logic clk_100M = 1'b0;
    logic reset;

    mem_loader_if bus ();

    mem_loader #(
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (512),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_100M (clk_100M),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_100M = ~clk_100M;

    int n_checks = 0;
    int n_errors = 0;

    // Write log gathered by the negedge monitor.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          hold_q[$];
    int          run_len     = 0;
    logic        prev_wr     = 1'b0;
    int          done_cnt    = 0;
    int          acc_cnt     = 0;
    int          rdy_in_wr   = 0;
    int          unstable    = 0;

    always @(negedge clk_100M) begin
        if (bus.done) done_cnt++;
        if (bus.in_valid && bus.in_ready) acc_cnt++;
        if (bus.wr_en && bus.in_ready) rdy_in_wr++;
        if (bus.wr_en) begin
            if (!prev_wr) begin
                wr_addr_q.push_back(bus.addr);
                wr_data_q.push_back(bus.w_data);
                run_len = 1;
            end else begin
                run_len++;
                if (bus.addr != wr_addr_q[$] || bus.w_data != wr_data_q[$]) unstable++;
            end
        end else if (prev_wr) begin
            hold_q.push_back(run_len);
        end
        prev_wr = bus.wr_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 200; t++) begin
            if (bus.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (bus.busy && t < budget) begin
            tick();
            t++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        hold_q.delete();
    endtask

    task automatic check_write(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wr_addr_q.size() && i < hold_q.size()) begin
            check({tag, "_addr"}, wr_addr_q[i], a);
            check({tag, "_data"}, wr_data_q[i], d);
            check({tag, "_hold"}, 32'(hold_q[i]), 32'(HOLD));
        end else begin
            check({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(i + 1));
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int a0;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        repeat (3) tick();

        // Reset values
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_addr",     bus.addr,          BASE);
        check("rst_w_data",   bus.w_data,        32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Normal two-word load
        clear_log();
        d0 = done_cnt;
        a0 = acc_cnt;
        pulse_start();
        check("norm_busy", 32'(bus.busy), 32'd1);
        check("norm_ready_len", 32'(bus.in_ready), 32'd1);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
        check("norm_wr_latency", 32'(bus.wr_en), 32'd1);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
        wait_idle(50);
        check("norm_nwr", 32'(wr_addr_q.size()), 32'd2);
        check_write("norm_w0", 0, BASE,           32'h1234_5678);
        check_write("norm_w1", 1, BASE + 32'd4,   32'hDEAD_BEEF);
        check("norm_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("norm_err", 32'(bus.err), 32'd0);
        check("norm_acc", 32'(acc_cnt - a0), 32'd10);

        // Zero length
        repeat (2) tick();
        clear_log();
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("zero_done", 32'(bus.done), 32'd1);
        tick();
        check("zero_busy_off", 32'(bus.busy), 32'd0);
        check("zero_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Over-length (N = 513)
        repeat (2) tick();
        clear_log();
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        check("over_done", 32'(bus.done), 32'd1);
        check("over_err", 32'(bus.err), 32'd1);
        a0 = acc_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        check("over_no_consume", 32'(acc_cnt - a0), 32'd0);
        check("over_err_sticky", 32'(bus.err), 32'd1);
        check("over_nwr", 32'(wr_addr_q.size()), 32'd0);
        check("over_done_cnt", 32'(done_cnt - d0), 32'd1);
        pulse_start();
        check("over_err_cleared", 32'(bus.err), 32'd0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_idle(10);

        // Backpressure and gaps, 5th byte presented during WRITE
        repeat (2) tick();
        clear_log();
        d0 = done_cnt;
        a0 = acc_cnt;
        rdy_in_wr = 0;
        pulse_start();
        send_byte(8'h01, 3); send_byte(8'h00, 0);
        send_byte(8'h0D, 2); send_byte(8'hF0, 5); send_byte(8'hAD, 1); send_byte(8'h0B, 3);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        check("bp_ready_in_write", 32'(bus.in_ready), 32'd0);
        wait_idle(50);
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("bp_acc", 32'(acc_cnt - a0), 32'd6);
        check("bp_rdy_in_wr", 32'(rdy_in_wr), 32'd0);
        check("bp_nwr", 32'(wr_addr_q.size()), 32'd1);
        check_write("bp_w0", 0, BASE, 32'h0BAD_F00D);
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Reset after two bytes of the second word
        repeat (2) tick();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        check("rstmid_busy_pre", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_wr_en", 32'(bus.wr_en), 32'd0);
        check("rstmid_busy",  32'(bus.busy),  32'd0);
        check("rstmid_addr",  bus.addr,       BASE);
        check("rstmid_wdata", bus.w_data,     32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check("rstmid_nwr", 32'(wr_addr_q.size()), 32'd1);
        check_write("rstmid_w0", 0, BASE, 32'h4433_2211);
        clear_log();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h0D, 0); send_byte(8'hF0, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
        wait_idle(50);
        check("reload_nwr", 32'(wr_addr_q.size()), 32'd1);
        check_write("reload_w0", 0, BASE, 32'hCAFE_F00D);

        // Start pulsed while busy is ignored
        repeat (2) tick();
        clear_log();
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        pulse_start();
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        pulse_start();
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
        wait_idle(50);
        repeat (5) tick();
        check("stray_busy_off", 32'(bus.busy), 32'd0);
        check("stray_nwr", 32'(wr_addr_q.size()), 32'd2);
        check_write("stray_w0", 0, BASE,         32'h0403_0201);
        check_write("stray_w1", 1, BASE + 32'd4, 32'hD4C3_B2A1);
        check("stray_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("hold_stable", 32'(unstable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
